// File: rtl/fc_pkg.sv
// fc_pkg: shared state type and arithmetic helpers for the FC lane engine.
package fc_pkg;

    typedef enum logic [2:0] {IDLE, BIAS, ACC, ACT, OUT, DONE} fc_state_t;

    // Working width of sat_shift; must cover the widest accumulator in use.
    localparam int SAT_W = 256;

    function automatic int acc_width(input int word_len, input int max_feat);
        return 2 * word_len + $clog2(max_feat + 1) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int frac_bits,
        input int word_len
    );
        logic signed [SAT_W-1:0] sh, hi, lo;
        sh = acc >>> frac_bits;
        hi = (SAT_W'(1) <<< (word_len - 1)) - SAT_W'(1);
        lo = ~hi;
        return (sh > hi) ? hi : (sh < lo) ? lo : sh;
    endfunction

endpackage

// File: rtl/fc_lane_mac.sv
// fc_lane_mac: one neuron lane - bias load, signed MAC, rescale/saturate/ReLU into a registered result.
module fc_lane_mac
    import fc_pkg::*;
#(
    parameter int WORD_LEN  = 32,
    parameter int MAX_FEAT  = 1024,
    parameter int FRAC_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bias_load,
    input  logic signed [WORD_LEN-1:0] bias,
    input  logic                       mac_en,
    input  logic signed [WORD_LEN-1:0] feat,
    input  logic signed [WORD_LEN-1:0] weight,
    input  logic                       act_en,
    input  logic                       relu_en,
    output logic        [WORD_LEN-1:0] res
);
    localparam int ACC_W = acc_width(WORD_LEN, MAX_FEAT);

    logic signed [ACC_W-1:0]      acc;
    logic signed [2*WORD_LEN-1:0] prod;
    logic signed [SAT_W-1:0]      r;

    assign prod = feat * weight;
    assign r    = sat_shift(SAT_W'(acc), FRAC_BITS, WORD_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            res <= '0;
        end else begin
            if (bias_load)
                acc <= ACC_W'(bias) <<< FRAC_BITS;
            else if (mac_en)
                acc <= acc + ACC_W'(prod);
            if (act_en)
                res <= (relu_en && r < 0) ? '0 : WORD_LEN'(r);
        end
    end
endmodule

// File: rtl/fc_lane_engine.sv
// fc_lane_engine: streaming FC engine computing LANES neurons per pass over the feature vector,
// emitting results serially per group.
module fc_lane_engine
    import fc_pkg::*;
#(
    parameter int WORD_LEN  = 32,
    parameter int LANES     = 4,
    parameter int MAX_FEAT  = 1024,
    parameter int MAX_OUT   = 1024,
    parameter int FRAC_BITS = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                fc_start,
    input  logic [$clog2(MAX_FEAT+1)-1:0]       cfg_feature_len,
    input  logic [$clog2(MAX_OUT+1)-1:0]        cfg_out_len,
    input  logic                                cfg_relu_en,
    input  logic [LANES*WORD_LEN-1:0]           bias_data,
    input  logic                                bias_valid,
    output logic                                bias_ready,
    input  logic [WORD_LEN-1:0]                 in_data,
    input  logic [LANES*WORD_LEN-1:0]           in_weight,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [WORD_LEN-1:0]                 res_data,
    output logic                                res_last,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic                                fc_busy,
    output logic                                fc_end
);
    localparam int FW = $clog2(MAX_FEAT + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int BW = OW + LW + 2;

    fc_state_t           state;
    logic [FW-1:0]       feat_len, fcnt;
    logic [OW-1:0]       out_len, grp;
    logic                relu_en;
    logic [LW-1:0]       lane, last_lane;
    logic [BW-1:0]       rem;
    logic                last_grp;
    logic [WORD_LEN-1:0] res [LANES];

    // Outputs still owed from the current group onward decide the group's width.
    assign rem       = BW'(out_len) - BW'(grp) * BW'(LANES);
    assign last_grp  = rem <= BW'(LANES);
    assign last_lane = last_grp ? LW'(rem - BW'(1)) : LW'(LANES - 1);

    assign bias_ready = state == BIAS;
    assign in_ready   = state == ACC;
    assign res_valid  = state == OUT;
    assign fc_busy    = state != IDLE;
    assign fc_end     = state == DONE;
    assign res_data   = res[lane];
    assign res_last   = state == OUT && lane == last_lane;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fc_lane_mac #(
            .WORD_LEN (WORD_LEN),
            .MAX_FEAT (MAX_FEAT),
            .FRAC_BITS(FRAC_BITS)
        ) u_mac (
            .clk      (clk),
            .rst_n    (rst_n),
            .bias_load(bias_ready && bias_valid),
            .bias     (bias_data[g*WORD_LEN +: WORD_LEN]),
            .mac_en   (in_ready && in_valid),
            .feat     (in_data),
            .weight   (in_weight[g*WORD_LEN +: WORD_LEN]),
            .act_en   (state == ACT),
            .relu_en  (relu_en),
            .res      (res[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            feat_len <= '0;
            out_len  <= '0;
            relu_en  <= 1'b0;
            grp      <= '0;
            fcnt     <= '0;
            lane     <= '0;
        end else begin
            case (state)
                IDLE: if (fc_start) begin
                    feat_len <= cfg_feature_len;
                    out_len  <= cfg_out_len;
                    relu_en  <= cfg_relu_en;
                    grp      <= '0;
                    if (cfg_out_len == '0) state <= DONE;
                    else                   state <= BIAS;
                end
                BIAS: if (bias_valid) begin
                    fcnt <= '0;
                    if (feat_len == '0) state <= ACT;
                    else                state <= ACC;
                end
                ACC: if (in_valid) begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == feat_len - FW'(1)) state <= ACT;
                end
                ACT: begin
                    lane  <= '0;
                    state <= OUT;
                end
                OUT: if (res_ready) begin
                    lane <= lane + LW'(1);
                    if (lane == last_lane) begin
                        if (last_grp) state <= DONE;
                        else begin
                            grp   <= grp + OW'(1);
                            state <= BIAS;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_lane_engine.sv
// tb_fc_lane_engine: directed self-checking bench for fc_lane_engine (Q16 operands, 4 lanes).
module tb_fc_lane_engine;
    localparam int W  = 32;
    localparam int L  = 4;
    localparam int MF = 16;
    localparam int MO = 16;
    localparam int FB = 16;
    localparam int FW = $clog2(MF + 1);
    localparam int OW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fc_start;
    logic [FW-1:0] cfg_feature_len;
    logic [OW-1:0] cfg_out_len;
    logic          cfg_relu_en;
    logic [L*W-1:0] bias_data;
    logic          bias_valid, bias_ready;
    logic [W-1:0]  in_data;
    logic [L*W-1:0] in_weight;
    logic          in_valid, in_ready;
    logic [W-1:0]  res_data;
    logic          res_last, res_valid, res_ready;
    logic          fc_busy, fc_end;

    fc_lane_engine #(
        .WORD_LEN(W), .LANES(L), .MAX_FEAT(MF), .MAX_OUT(MO), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fc_start(fc_start),
        .cfg_feature_len(cfg_feature_len), .cfg_out_len(cfg_out_len), .cfg_relu_en(cfg_relu_en),
        .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
        .in_data(in_data), .in_weight(in_weight), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready),
        .fc_busy(fc_busy), .fc_end(fc_end)
    );

    always #5 clk = ~clk;

    logic [W-1:0]   fmem [MF];
    logic [L*W-1:0] wmem [MF];
    logic [L*W-1:0] bmem [8];
    logic [W-1:0]   got [16];
    logic           got_last [16];
    logic [W-1:0]   exp_d [16];
    logic           exp_l [16];
    int             nres;
    bit             ended;
    int             n_chk = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [W-1:0] g, input logic [W-1:0] e);
        n_chk++;
        assert (g === e) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, g, e);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " bias_ready"}, W'(bias_ready), 0);
        chk({tag, " in_ready"},   W'(in_ready), 0);
        chk({tag, " res_valid"},  W'(res_valid), 0);
        chk({tag, " res_data"},   res_data, 0);
        chk({tag, " res_last"},   W'(res_last), 0);
        chk({tag, " fc_busy"},    W'(fc_busy), 0);
        chk({tag, " fc_end"},     W'(fc_end), 0);
    endtask

    // Drives one job; inputs change on negedges, handshakes complete on the following posedge.
    task automatic run_job(input int fl, input int ol, input bit relu, input bit gaps, input int abort);
        int b, f, in_cnt;
        bit stall;
        logic [W-1:0] held;
        nres = 0; ended = 0; b = 0; f = 0; in_cnt = 0; stall = 0; held = '0;
        @(negedge clk);
        fc_start = 1'b1;
        cfg_feature_len = FW'(fl);
        cfg_out_len = OW'(ol);
        cfg_relu_en = relu;
        @(negedge clk);
        fc_start = 1'b0;
        cfg_feature_len = FW'(7);
        cfg_out_len = OW'(9);
        cfg_relu_en = ~relu;
        for (int c = 0; c < 2000; c++) begin
            if (abort >= 0 && in_cnt == abort) begin
                #2 rst_n = 1'b0;
                #1 chk_idle_outputs("abort");
                in_valid = 1'b0; bias_valid = 1'b0; res_ready = 1'b0;
                return;
            end
            if (fc_end) begin
                ended = 1;
                break;
            end
            if (stall) begin
                chk("stall res_data", res_data, held);
                chk("stall res_valid", W'(res_valid), 1);
            end
            bias_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bias_data  = bmem[b];
            in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data    = fmem[f];
            in_weight  = wmem[f];
            res_ready  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bias_valid && bias_ready) begin
                b++;
                f = 0;
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                f = (f + 1 == fl) ? 0 : f + 1;
            end
            if (res_valid && res_ready && nres < 16) begin
                got[nres] = res_data;
                got_last[nres] = res_last;
                nres++;
            end
            stall = res_valid && !res_ready;
            held = res_data;
            @(negedge clk);
        end
        bias_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        chk("fc_end seen", W'(ended), 1);
        @(negedge clk);
        chk("fc_end one cycle", W'(fc_end), 0);
        chk("idle after job", W'(fc_busy), 0);
    endtask

    task automatic expect_res(input string tag, input int n);
        chk({tag, " beats"}, W'(nres), W'(n));
        for (int i = 0; i < n && i < nres; i++) begin
            chk($sformatf("%s data[%0d]", tag, i), got[i], exp_d[i]);
            chk($sformatf("%s last[%0d]", tag, i), W'(got_last[i]), W'(exp_l[i]));
        end
    endtask

    task automatic load_basic();
        fmem[0] = 32'h0001_0000; fmem[1] = 32'h0002_0000; fmem[2] = 32'h0003_0000;
        for (int i = 0; i < 3; i++) wmem[i] = {4{32'h0001_0000}};
        bmem[0] = {32'h0064_0000, 32'hFFFB_0000, 32'h000A_0000, 32'h0000_0000};
        bmem[1] = {32'h004D_0000, 32'h004D_0000, 32'h0002_0000, 32'h0001_0000};
        exp_d[0] = 32'h0006_0000; exp_d[1] = 32'h0010_0000;
        exp_d[2] = 32'h0001_0000; exp_d[3] = 32'h006A_0000;
        exp_d[4] = 32'h0007_0000; exp_d[5] = 32'h0008_0000;
        exp_l[0] = 0; exp_l[1] = 0; exp_l[2] = 0; exp_l[3] = 1; exp_l[4] = 0; exp_l[5] = 1;
    endtask

    initial begin
        rst_n = 1'b0; fc_start = 1'b0; cfg_feature_len = '0; cfg_out_len = '0; cfg_relu_en = 1'b0;
        bias_data = '0; bias_valid = 1'b0; in_data = '0; in_weight = '0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        load_basic();
        run_job(3, 4, 0, 0, -1);
        expect_res("basic", 4);
        run_job(3, 6, 0, 0, -1);
        expect_res("partial", 6);
        run_job(3, 6, 0, 1, -1);
        expect_res("backpressure", 6);

        fmem[0] = 32'h7FFF_FFFF; fmem[1] = 32'h7FFF_FFFF;
        wmem[0] = {4{32'h7FFF_FFFF}}; wmem[1] = {4{32'h7FFF_FFFF}};
        bmem[0] = '0;
        exp_d[0] = 32'h7FFF_FFFF; exp_l[0] = 1;
        run_job(2, 1, 0, 0, -1);
        expect_res("sat pos", 1);
        wmem[0] = {4{32'h8000_0001}}; wmem[1] = {4{32'h8000_0001}};
        exp_d[0] = 32'h8000_0000;
        run_job(2, 1, 0, 0, -1);
        expect_res("sat neg", 1);
        exp_d[0] = 32'h0;
        run_job(2, 1, 1, 0, -1);
        expect_res("relu", 1);

        fmem[0] = 32'h0001_8000;
        wmem[0] = {32'h0000_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000};
        bmem[0] = {32'h0001_0000, 32'h0, 32'h0, 32'h0};
        exp_d[0] = 32'h0003_0000; exp_d[1] = 32'hFFFE_8000;
        exp_d[2] = 32'h0000_C000; exp_d[3] = 32'h0001_0000;
        exp_l[0] = 0; exp_l[1] = 0; exp_l[2] = 0; exp_l[3] = 1;
        run_job(1, 4, 0, 1, -1);
        expect_res("fixed", 4);
        exp_d[1] = 32'h0;
        run_job(1, 4, 1, 0, -1);
        expect_res("fixed relu", 4);

        load_basic();
        exp_d[0] = 32'h0000_0000; exp_d[1] = 32'h000A_0000;
        exp_d[2] = 32'hFFFB_0000; exp_d[3] = 32'h0064_0000;
        run_job(0, 4, 0, 0, -1);
        expect_res("no features", 4);

        run_job(3, 0, 0, 0, -1);
        expect_res("no outputs", 0);

        load_basic();
        run_job(3, 4, 0, 0, 1);
        @(negedge clk);
        chk_idle_outputs("held reset");
        rst_n = 1'b1;
        run_job(3, 4, 0, 0, -1);
        expect_res("after abort", 4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
